// File: rtl/cell_sched_pkg.sv
// Shared constants and types for the character-cell RAM scheduler.
package cell_sched_pkg;

    localparam logic [6:0] SPACE_CODE = 7'h20;
    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 23;
    localparam int CELLS      = COLS_DEF * ROWS_DEF;
    localparam int ADDR_W_DEF = 11;
    localparam int CHAR_W_DEF = 7;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [CHAR_W_DEF-1:0] data;
    } host_entry_t;

endpackage

// File: rtl/cell_sched_fifo.sv
// Synchronous FIFO with occupancy count; head entry is visible combinationally on rdata.
module cell_sched_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cell_ram_scheduler.sv
// Cell RAM access scheduler: fixed-latency display fetches, buffered host writes, clear-screen FSM.
// Define CELL_SCHED_STATS_EN to build the saturating host-stall counter behind stall_cycles.
module cell_ram_scheduler
    import cell_sched_pkg::*;
#(
    parameter int COLS       = COLS_DEF,
    parameter int ROWS       = ROWS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CHAR_W     = CHAR_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [7:0]        fetch_cx,
    input  logic [7:0]        fetch_cy,
    output logic              fetch_valid,
    output logic [CHAR_W-1:0] fetch_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [CHAR_W-1:0] host_data,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [CHAR_W-1:0] ram_wdata,
    input  logic [CHAR_W-1:0] ram_rdata,
    output logic [15:0]       stall_cycles
);

    localparam int CELLS_P = COLS * ROWS;
    localparam int ENT_W   = ADDR_W + CHAR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int LIN_W   = ADDR_W + 1;
    localparam logic [CHAR_W-1:0] SPACE_CHAR = CHAR_W'(SPACE_CODE);

    state_t            state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              clear_busy_r;
    logic              host_ready_r;
    logic              f1_valid_r;
    logic              f1_oob_r;
    logic [LIN_W-1:0]  fetch_lin_s;
    logic              fetch_oob_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [ENT_W-1:0]  fifo_head_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [CHAR_W-1:0] head_data_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W-1:0]  count_next_s;

    assign fetch_lin_s = LIN_W'(fetch_cy) * LIN_W'(COLS) + LIN_W'(fetch_cx);
    assign fetch_oob_s = (32'(fetch_cx) >= 32'(COLS)) || (32'(fetch_cy) >= 32'(ROWS));
    assign head_addr_s = fifo_head_s[ENT_W-1:CHAR_W];
    assign head_data_s = fifo_head_s[CHAR_W-1:0];
    assign push_s      = host_valid && host_ready_r && !fifo_full_s && !reset;
    assign host_ready  = host_ready_r && !reset;
    assign clear_busy  = clear_busy_r;

    cell_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({host_addr, host_data}),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Slot arbitration: fetch, then clear write, then host pop; out-of-range pops consume the slot silently.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {CHAR_W{1'b0}};
        pop_s     = 1'b0;
        if (reset) begin
            pop_s = 1'b0;
        end else if (fetch_req) begin
            if (!fetch_oob_s) begin
                ram_en   = 1'b1;
                ram_addr = fetch_lin_s[ADDR_W-1:0];
            end else begin
                ram_en = 1'b0;
            end
        end else if (state_r == CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr_r;
            ram_wdata = SPACE_CHAR;
        end else if (!fifo_empty_s) begin
            pop_s = 1'b1;
            if (32'(head_addr_s) < 32'(CELLS_P)) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = head_addr_s;
                ram_wdata = head_data_s;
            end else begin
                ram_en = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Occupancy after this cycle's push/pop, used to register host_ready.
    always_comb begin
        count_next_s = fifo_count_s;
        if (push_s && !pop_s) begin
            count_next_s = fifo_count_s + CNT_W'(1'b1);
        end else if (!push_s && pop_s) begin
            count_next_s = fifo_count_s - CNT_W'(1'b1);
        end else begin
            count_next_s = fifo_count_s;
        end
    end

    // host_ready register; held at 1 through reset so it is high on the first cycle after.
    always_ff @(posedge clock) begin
        if (reset) begin
            host_ready_r <= 1'b1;
        end else begin
            host_ready_r <= (count_next_s != CNT_W'(FIFO_DEPTH));
        end
    end

    // Clear-screen FSM; a fetch stalls the sweep without losing its place.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            clr_addr_r   <= {ADDR_W{1'b0}};
            clear_busy_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear_start) begin
                        state_r      <= CLEAR;
                        clr_addr_r   <= {ADDR_W{1'b0}};
                        clear_busy_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!fetch_req) begin
                        if (clr_addr_r == ADDR_W'(CELLS_P - 1)) begin
                            state_r      <= IDLE;
                            clear_busy_r <= 1'b0;
                        end else begin
                            clr_addr_r <= clr_addr_r + ADDR_W'(1'b1);
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    clear_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-stage fetch return: RAM data arrives one cycle after the read, registered a cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            f1_valid_r  <= 1'b0;
            f1_oob_r    <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= {CHAR_W{1'b0}};
        end else begin
            f1_valid_r  <= fetch_req;
            f1_oob_r    <= fetch_oob_s;
            fetch_valid <= f1_valid_r;
            if (f1_valid_r) begin
                fetch_data <= f1_oob_r ? SPACE_CHAR : ram_rdata;
            end
        end
    end

`ifdef CELL_SCHED_STATS_EN
    logic [15:0] stall_r;

    // Saturating count of cycles with queued host writes that could not retire.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_r <= 16'h0000;
        end else if (!fifo_empty_s && !pop_s && (stall_r != 16'hFFFF)) begin
            stall_r <= stall_r + 16'h0001;
        end
    end

    assign stall_cycles = stall_r;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_cell_ram_scheduler.sv
// Bench for cell_ram_scheduler: queue-level scheduling model checked every cycle, plus directed scenarios.
module tb_cell_ram_scheduler;
    import cell_sched_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 23;
    localparam int DEPTH = 4;
    localparam int NCELL = COLS * ROWS;
`ifdef CELL_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [7:0]  fetch_cx = 8'd0;
    logic [7:0]  fetch_cy = 8'd0;
    logic        fetch_valid;
    logic [6:0]  fetch_data;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [10:0] host_addr = 11'd0;
    logic [6:0]  host_data = 7'd0;
    logic        clear_start = 1'b0;
    logic        clear_busy;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [6:0]  ram_wdata;
    logic [6:0]  ram_rdata = 7'h00;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_total = 0;
    bit mem_init = 1'b0;
    logic [6:0] mem [0:2047];
    int wr_cycle [0:2047];

    cell_ram_scheduler dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_cx(fetch_cx), .fetch_cy(fetch_cy),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Cell RAM: one-cycle read latency, write log per address, cycle counter.
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) begin
                mem[i]      <= 7'(i * 3 + 1);
                wr_cycle[i] <= -1;
            end
            mem[163] <= 7'h41;
            mem_init <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]      <= ram_wdata;
                wr_cycle[ram_addr] <= cyc;
                wr_total           <= wr_total + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
        cyc <= cyc + 1;
    end

    // Reference model: host write queue, clear sweep index and fetch return pipeline.
    host_entry_t mq[$];
    bit         m_live = 1'b0, m_clr = 1'b0, m_ready = 1'b0, p1_v = 1'b0, m_fv = 1'b0;
    int         m_idx = 0, m_stall = 0;
    logic [6:0] p1_d = 7'h00, m_fd = 7'h00;

    always @(negedge clock) begin
        bit e_en, e_we, popd, oob;
        int e_addr, lin;
        logic [6:0] e_wd;
        e_en = 1'b0; e_we = 1'b0; popd = 1'b0; e_addr = 0; e_wd = 7'h00;
        oob = (fetch_cx >= COLS) || (fetch_cy >= ROWS);
        lin = int'(fetch_cy) * COLS + int'(fetch_cx);
        if (!reset) begin
            if (fetch_req) begin
                if (!oob) begin e_en = 1'b1; e_addr = lin; end
            end else if (m_clr) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = m_idx; e_wd = 7'h20;
            end else if (mq.size() > 0) begin
                popd = 1'b1;
                if (mq[0].addr < NCELL) begin
                    e_en = 1'b1; e_we = 1'b1; e_addr = mq[0].addr; e_wd = mq[0].data;
                end
            end
        end
        if (m_live) begin
            chk("ram_en", ram_en, e_en);
            chk("ram_we", ram_we, e_we);
            if (e_en) chk("ram_addr", ram_addr, e_addr);
            if (e_we) chk("ram_wdata", ram_wdata, e_wd);
            chk("host_ready", host_ready, (!reset && m_ready));
            chk("clear_busy", clear_busy, m_clr);
            chk("fetch_valid", fetch_valid, m_fv);
            if (m_fv) chk("fetch_data", fetch_data, m_fd);
            chk("stall_cycles", stall_cycles, STATS ? m_stall : 0);
        end
        if (reset) begin
            mq.delete();
            m_clr = 1'b0; m_idx = 0; m_ready = 1'b1; p1_v = 1'b0; m_fv = 1'b0; m_stall = 0;
            m_live = 1'b1;
        end else begin
            if (mq.size() > 0 && !popd && m_stall < 65535) m_stall++;
            if (popd) void'(mq.pop_front());
            if (host_valid && m_ready) mq.push_back('{host_addr, host_data});
            if (m_clr) begin
                if (!fetch_req) begin
                    if (m_idx == NCELL - 1) m_clr = 1'b0;
                    else m_idx++;
                end
            end else if (clear_start) begin
                m_clr = 1'b1; m_idx = 0;
            end
            m_ready = (mq.size() != DEPTH);
            m_fv = p1_v;
            if (p1_v) m_fd = p1_d;
            p1_v = fetch_req;
            if (oob) p1_d = 7'h20;
            else p1_d = mem[lin];
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int base, s, busy_n, idx, n, wr_before;
        bit done;
        int acc[5];

        repeat (3) tick();
        reset = 1'b0;
        #2;
        chk("rst_host_ready", host_ready, 1);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_stall", stall_cycles, 0);
        repeat (2) tick();

        // In-range fetch (3,2) -> address 163
        tick(); fetch_req = 1'b1; fetch_cx = 8'd3; fetch_cy = 8'd2;
        #2;
        chk("fetch_addr", ram_addr, 163);
        chk("fetch_en", ram_en, 1);
        chk("fetch_we", ram_we, 0);
        tick(); fetch_req = 1'b0;
        tick(); #2;
        chk("fetch_valid_t2", fetch_valid, 1);
        chk("fetch_data_t2", fetch_data, 7'h41);

        // Out-of-range column returns SPACE without a RAM access
        tick(); fetch_req = 1'b1; fetch_cx = 8'd80; fetch_cy = 8'd0;
        #2;
        chk("oob_no_en", ram_en, 0);
        tick(); fetch_req = 1'b0;
        tick(); #2;
        chk("oob_valid", fetch_valid, 1);
        chk("oob_data", fetch_data, 7'h20);

        // Ten fetch cycles starve one queued host write
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) base = cyc;
            fetch_req = 1'b1; fetch_cx = 8'(k); fetch_cy = (k == 5) ? 8'd23 : 8'd1;
            host_valid = (k == 0); host_addr = 11'd5; host_data = 7'h48;
        end
        tick(); fetch_req = 1'b0; host_valid = 1'b0;
        tick(); #2;
        chk("stall_9", stall_cycles, STATS ? 9 : 0);
        chk("wr5_cycle", wr_cycle[5], base + 10);
        chk("wr5_data", mem[5], 7'h48);

        // Five writes against a full FIFO during fetches
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 0) base = cyc;
            fetch_req = (k < 8); fetch_cx = 8'd0; fetch_cy = 8'd0;
            host_valid = (idx < 5); host_addr = 11'(10 + idx); host_data = 7'(32'h50 + idx);
            #2;
            if (k == 4) chk("ready_full", host_ready, 0);
            if (k == 8) chk("ready_pop_same_cycle", host_ready, 0);
            if (host_valid && host_ready) begin
                acc[idx] = cyc;
                idx++;
            end
        end
        host_valid = 1'b0;
        chk("acc_count", idx, 5);
        chk("acc5_cycle", acc[4], base + 9);
        for (int i = 0; i < 5; i++) begin
            chk("burst_wr_cycle", wr_cycle[10 + i], base + 8 + i);
            chk("burst_wr_data", mem[10 + i], 32'h50 + i);
        end

        // Full-screen clear with a host write queued part way through
        tick(); clear_start = 1'b1; s = cyc;
        tick(); clear_start = 1'b0;
        busy_n = 0; n = 0; done = 1'b0;
        while (!done && n < 2100) begin
            host_valid = (n == 100); host_addr = 11'd7; host_data = 7'h55;
            #2;
            if (clear_busy) busy_n++;
            else done = 1'b1;
            if (!done) begin tick(); n++; end
        end
        host_valid = 1'b0;
        chk("clear_done", done, 1);
        tick(); tick(); #2;
        chk("clear_busy_cycles", busy_n, 1840);
        chk("clear_first", wr_cycle[0], s + 1);
        chk("clear_last", wr_cycle[1839], s + 1840);
        chk("clear_data0", mem[0], 7'h20);
        chk("clear_data1839", mem[1839], 7'h20);
        chk("post_clear_wr", wr_cycle[7], s + 1841);
        chk("post_clear_data", mem[7], 7'h55);

        // Host write past the last cell is discarded
        tick(); host_valid = 1'b1; host_addr = 11'd1840; host_data = 7'h2A;
        tick(); host_valid = 1'b0;
        tick(); tick(); #2;
        chk("oob_host_nowr", wr_cycle[1840], -1);
        chk("oob_host_mem", mem[1840], 7'd17);

        // Reset in the cycle the sweep reaches address 100
        tick(); clear_start = 1'b1; s = cyc;
        tick(); clear_start = 1'b0;
        repeat (100) tick();
        reset = 1'b1;
        #2;
        chk("midclr_cycle", cyc, s + 101);
        chk("midclr_gate", ram_en, 0);
        wr_before = wr_total;
        tick(); reset = 1'b0;
        #2;
        chk("midclr_busy", clear_busy, 0);
        repeat (5) tick();
        #2;
        chk("midclr_nowr", wr_total, wr_before);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
